// File: rtl/vga_pixel_fifo.sv
// ---------------------------------------------------------------------------
// vga_pixel_fifo
//   Pixel source FIFO in the clk_pixel domain, directly upstream of the vga
//   timing generator. It accepts RGB888 pixels over a valid/ready stream and
//   presents one pixel per fetch_next strobe with one cycle of read latency.
//   Storage for the line currently being scanned stays reserved until the
//   next line starts. A rising edge on line_repeat therefore replays the
//   current line (y-doublescan).
//
// Parameters
//   C_addr_bits  log2 of FIFO depth (depth = 2**C_addr_bits pixels)
//   C_line_len   pixels per displayed line (equals the vga horizontal size)
//
// Ports
//   clk_pixel    pixel clock, the only clock
//   reset        synchronous, active-high reset
//   in_data      pixel {r[23:16], g[15:8], b[7:0]}
//   in_valid     in_data valid
//   in_ready     FIFO can accept; a write occurs on in_valid & in_ready
//   fetch_next   pop request from the vga stage
//   line_repeat  level; its rising edge rewinds to the held line start
//   red_byte     popped pixel, red   (valid the cycle after the pop)
//   green_byte   popped pixel, green
//   blue_byte    popped pixel, blue
//   underflow    one-cycle pulse aligned with the bytes: pop requested while empty
//   level        readable entries (wr_ptr - rd_ptr)
//
// Build option
//   VGA_PIXEL_FIFO_UNDERFLOW_FILL_EN : when defined, an underflow loads magenta
//   (FF/00/FF) into the bytes so starvation is visible on screen; otherwise
//   the bytes hold the last popped pixel.
// ---------------------------------------------------------------------------
module vga_pixel_fifo #(
  parameter int C_addr_bits = 10,
  parameter int C_line_len  = 640
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic [23:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 fetch_next,
  input  logic                 line_repeat,
  output logic [7:0]           red_byte,
  output logic [7:0]           green_byte,
  output logic [7:0]           blue_byte,
  output logic                 underflow,
  output logic [C_addr_bits:0] level
);

  localparam int AW = C_addr_bits;
  localparam int CW = (C_line_len > 1) ? $clog2(C_line_len) : 1;
  localparam logic [CW-1:0] LAST_POP  = CW'(C_line_len - 1);
  // held == depth means every slot is either unread or reserved for replay
  localparam logic [AW:0]   FULL_HELD = {1'b1, {AW{1'b0}}};

`ifdef VGA_PIXEL_FIFO_UNDERFLOW_FILL_EN
  localparam logic FILL_EN = 1'b1;
`else
  localparam logic FILL_EN = 1'b0;
`endif

  logic [23:0]   mem [0:(2**AW)-1];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   mark;
  logic [CW-1:0] pop_cnt;
  logic          replay;
  logic          line_repeat_d;
  logic [23:0]   pix_p1;

  logic          rew;
  logic          empty;
  logic          wr_en;
  logic          pop_en;
  logic          uf_en;
  logic          line_start;
  logic [AW:0]   wr_ptr_nxt;
  logic [AW:0]   mark_nxt;
  logic [AW:0]   held_nxt;

  always_comb begin
    rew        = line_repeat & ~line_repeat_d;
    empty      = (wr_ptr == rd_ptr);
    wr_en      = in_valid & in_ready;
    // A rewind takes priority: the colliding pop is dropped, not flagged
    pop_en     = fetch_next & ~empty & ~rew;
    uf_en      = fetch_next & empty & ~rew;
    // Replayed lines must not move mark, or the line could not be replayed again
    line_start = pop_en & (pop_cnt == '0) & ~replay;
    wr_ptr_nxt = wr_en ? (wr_ptr + 1'b1) : wr_ptr;
    mark_nxt   = line_start ? rd_ptr : mark;
    // in_ready is registered, so it is computed from next-state pointers to
    // drop on the very edge that fills the last free slot
    held_nxt   = wr_ptr_nxt - mark_nxt;
  end

  always_ff @(posedge clk_pixel) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mark          <= '0;
      pop_cnt       <= '0;
      replay        <= 1'b0;
      line_repeat_d <= 1'b0;
      in_ready      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      line_repeat_d <= line_repeat;
      wr_ptr        <= wr_ptr_nxt;
      mark          <= mark_nxt;
      in_ready      <= (held_nxt != FULL_HELD);
      underflow     <= uf_en;
      if (rew) begin
        rd_ptr  <= mark;
        pop_cnt <= '0;
        replay  <= 1'b1;
      end else if (pop_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (pop_cnt == LAST_POP) begin
          pop_cnt <= '0;
          replay  <= 1'b0;
        end else begin
          pop_cnt <= pop_cnt + 1'b1;
        end
      end
    end
  end

  // ---- stage p1: output pixel register, one cycle after the pop ----
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pix_p1 <= '0;
    end else if (pop_en) begin
      pix_p1 <= mem[rd_ptr[AW-1:0]];
    end else if (uf_en && FILL_EN) begin
      pix_p1 <= 24'hFF00FF;
    end
  end

  assign red_byte   = pix_p1[23:16];
  assign green_byte = pix_p1[15:8];
  assign blue_byte  = pix_p1[7:0];
  assign level      = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
module tb_vga_pixel_fifo;

  localparam int AW = 3;
  localparam int LL = 4;

  logic          clk_pixel = 1'b0;
  logic          reset = 1'b1;
  logic [23:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          fetch_next = 1'b0;
  logic          line_repeat = 1'b0;
  logic [7:0]    red_byte, green_byte, blue_byte;
  logic          underflow;
  logic [AW:0]   level;

  int            errors = 0;
  int            checks = 0;
  logic [23:0]   exp_q[$];

  vga_pixel_fifo #(.C_addr_bits(AW), .C_line_len(LL)) dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fetch_next (fetch_next),
    .line_repeat(line_repeat),
    .red_byte   (red_byte),
    .green_byte (green_byte),
    .blue_byte  (blue_byte),
    .underflow  (underflow),
    .level      (level)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Advance one active edge and settle just after it
  task automatic cyc();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; fetch_next = 1'b0; line_repeat = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    exp_q.delete();
  endtask

  task automatic write_px(input logic [23:0] d);
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; fetch_next = 1'b0; line_repeat = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({red_byte, green_byte, blue_byte} !== 24'h0) begin
      errors++; $display("FAIL reset_bytes got %h want 000000", {red_byte, green_byte, blue_byte});
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", underflow); end
    reset = 1'b0;
    cyc();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
    checks++;
    if (level !== '0) begin errors++; $display("FAIL release_level got %0d want 0", level); end
  endtask

  task automatic test_basic();
    logic [23:0] got, want;
    write_px(24'h112233); exp_q.push_back(24'h112233);
    write_px(24'h445566); exp_q.push_back(24'h445566);
    write_px(24'h778899); exp_q.push_back(24'h778899);
    checks++;
    if (level !== 4'd3) begin errors++; $display("FAIL basic_level_full got %0d want 3", level); end
    for (int i = 0; i < 3; i++) begin
      fetch_next = 1'b1;
      cyc();
      got = {red_byte, green_byte, blue_byte};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL basic_pop%0d got %h want %h", i, got, want); end
    end
    fetch_next = 1'b0;
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL basic_level_empty got %0d want 0", level); end
  endtask

  task automatic test_underflow();
    logic [23:0] got, want, uf_want;
    write_px(24'hAABBCC); exp_q.push_back(24'hAABBCC);
    fetch_next = 1'b1;
    cyc();
    got = {red_byte, green_byte, blue_byte};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL uf_prefill got %h want %h", got, want); end
`ifdef VGA_PIXEL_FIFO_UNDERFLOW_FILL_EN
    uf_want = 24'hFF00FF;
`else
    uf_want = 24'hAABBCC;
`endif
    cyc();                // fetch_next still high, FIFO now empty
    fetch_next = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse got %b want 1", underflow); end
    got = {red_byte, green_byte, blue_byte};
    checks++;
    if (got !== uf_want) begin errors++; $display("FAIL uf_bytes got %h want %h", got, uf_want); end
    cyc();
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_pulse_end got %b want 0", underflow); end
    got = {red_byte, green_byte, blue_byte};
    checks++;
    if (got !== uf_want) begin errors++; $display("FAIL uf_bytes_hold got %h want %h", got, uf_want); end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL uf_level got %0d want 0", level); end
  endtask

  task automatic test_line_repeat();
    logic [23:0] got, want;
    do_reset();
    for (int i = 0; i < 8; i++) write_px(24'hA00000 + 24'(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(24'hA00000 + 24'(i));
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL lr_full_ready got %b want 0", in_ready); end
    checks++;
    if (level !== 4'd8) begin errors++; $display("FAIL lr_level_full got %0d want 8", level); end
    for (int i = 0; i < 4; i++) begin
      fetch_next = 1'b1;
      cyc();
      got = {red_byte, green_byte, blue_byte};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL lr_first%0d got %h want %h", i, got, want); end
    end
    fetch_next = 1'b0;
    line_repeat = 1'b1;
    cyc();
    checks++;
    if (level !== 4'd8) begin errors++; $display("FAIL lr_rewind_level got %0d want 8", level); end
    for (int i = 0; i < 4; i++) exp_q.push_back(24'hA00000 + 24'(i));
    for (int i = 4; i < 8; i++) exp_q.push_back(24'hA00000 + 24'(i));
    for (int i = 0; i < 8; i++) begin
      fetch_next = 1'b1;
      cyc();
      got = {red_byte, green_byte, blue_byte};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL lr_replay%0d got %h want %h", i, got, want); end
    end
    fetch_next = 1'b0;
    line_repeat = 1'b0;
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL lr_level_end got %0d want 0", level); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lr_ready_end got %b want 1", in_ready); end
  endtask

  task automatic test_full();
    logic [23:0] got, want;
    int acc;
    logic taken;
    do_reset();
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 24'hB00000 + 24'(acc);
      taken = in_ready;
      cyc();
      if (taken) begin
        if (acc < 5) exp_q.push_back(24'hB00000 + 24'(acc));
        acc++;
      end
    end
    checks++;
    if (acc != 8) begin errors++; $display("FAIL full_accepted got %0d want 8", acc); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
    in_data = 24'hB00000 + 24'(acc);
    for (int i = 0; i < 5; i++) begin
      fetch_next = 1'b1;
      cyc();
      got = {red_byte, green_byte, blue_byte};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL full_pop%0d got %h want %h", i, got, want); end
      checks++;
      if (in_ready !== (i == 4)) begin
        errors++; $display("FAIL full_ready_pop%0d got %b want %b", i, in_ready, (i == 4));
      end
    end
    fetch_next = 1'b0;
    in_valid = 1'b0;
    cyc();
    checks++;
    if (level !== 4'd3) begin errors++; $display("FAIL full_level got %0d want 3", level); end
  endtask

  task automatic test_rewind_collision();
    logic [23:0] got, want;
    do_reset();
    for (int i = 0; i < 6; i++) write_px(24'hC00000 + 24'(i));
    exp_q.push_back(24'hC00000);
    exp_q.push_back(24'hC00001);
    for (int i = 0; i < 2; i++) begin
      fetch_next = 1'b1;
      cyc();
      got = {red_byte, green_byte, blue_byte};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin errors++; $display("FAIL coll_pop%0d got %h want %h", i, got, want); end
    end
    line_repeat = 1'b1;     // fetch_next still high in this cycle
    cyc();
    fetch_next = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL coll_underflow got %b want 0", underflow); end
    got = {red_byte, green_byte, blue_byte};
    checks++;
    if (got !== 24'hC00001) begin errors++; $display("FAIL coll_hold got %h want c00001", got); end
    checks++;
    if (level !== 4'd6) begin errors++; $display("FAIL coll_level got %0d want 6", level); end
    exp_q.push_back(24'hC00000);
    fetch_next = 1'b1;
    cyc();
    fetch_next = 1'b0;
    line_repeat = 1'b0;
    got = {red_byte, green_byte, blue_byte};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL coll_restart got %h want %h", got, want); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got, want;
    do_reset();
    write_px(24'hD00000); exp_q.push_back(24'hD00000);
    in_valid = 1'b1; in_data = 24'hD00001; fetch_next = 1'b1;
    cyc();
    in_valid = 1'b0;
    got = {red_byte, green_byte, blue_byte};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL b2b_pop got %h want %h", got, want); end
    checks++;
    if (level !== 4'd1) begin errors++; $display("FAIL b2b_level got %0d want 1", level); end
    exp_q.push_back(24'hD00001);
    cyc();                  // fetch_next still high: pops D00001
    got = {red_byte, green_byte, blue_byte};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL b2b_pop2 got %h want %h", got, want); end
    in_valid = 1'b1; in_data = 24'hD00002;
    cyc();                  // empty: pop underflows, write lands
    in_valid = 1'b0; fetch_next = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL b2b_underflow got %b want 1", underflow); end
    checks++;
    if (level !== 4'd1) begin errors++; $display("FAIL b2b_level_uf got %0d want 1", level); end
    exp_q.push_back(24'hD00002);
    fetch_next = 1'b1;
    cyc();
    fetch_next = 1'b0;
    got = {red_byte, green_byte, blue_byte};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin errors++; $display("FAIL b2b_pop3 got %h want %h", got, want); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_line_repeat();
    test_full();
    test_rewind_collision();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
